// File: rtl/hazard_ctrl.sv
// Pipeline interlock controller: load-use stalls, taken-branch squashes, mul/div occupancy and halt.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        is_Ld_ALU,
  input  logic        isWb_ALU,
  input  logic [4:0]  rd_ALU,
  input  logic [4:0]  RP1_OF,
  input  logic        rp1_valid_OF,
  input  logic [4:0]  RP2_OF,
  input  logic        rp2_valid_OF,
  input  logic        branch_taken_ALU,
  input  logic        is_MulDiv_ALU,
  input  logic        is_Hlt_ALU,
  output logic        stall_PC,
  output logic        stall_IFOF,
  output logic        stall_OFALU,
  output logic        bubble_OFALU,
  output logic        flush_IFOF,
  output logic        bubble_ALUMA,
  output logic        halted,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned PERF_W   = 16;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 2);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    BUSY = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic lu_c;
  logic stall_pc_c, stall_ifof_c, stall_ofalu_c, bubble_ofalu_c;
  logic flush_ifof_c, bubble_aluma_c, halted_c;

  assign lu_c = is_Ld_ALU & isWb_ALU &
                ((rp1_valid_OF & (RP1_OF == rd_ALU)) |
                 (rp2_valid_OF & (RP2_OF == rd_ALU)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and control decode; RUN events are strictly prioritised.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    stall_pc_c     = 1'b0;
    stall_ifof_c   = 1'b0;
    stall_ofalu_c  = 1'b0;
    bubble_ofalu_c = 1'b0;
    flush_ifof_c   = 1'b0;
    bubble_aluma_c = 1'b0;
    halted_c       = 1'b0;
    unique case (state_q)
      RUN: begin
        if (is_Hlt_ALU) begin
          stall_pc_c     = 1'b1;
          stall_ifof_c   = 1'b1;
          stall_ofalu_c  = 1'b1;
          bubble_aluma_c = 1'b1;
          state_d        = HALT;
        end else if (branch_taken_ALU) begin
          flush_ifof_c   = 1'b1;
          bubble_ofalu_c = 1'b1;
        end else if (is_MulDiv_ALU) begin
          stall_pc_c     = 1'b1;
          stall_ifof_c   = 1'b1;
          stall_ofalu_c  = 1'b1;
          bubble_aluma_c = 1'b1;
          cnt_d          = CNT_LOAD;
          state_d        = BUSY;
        end else if (lu_c) begin
          stall_pc_c     = 1'b1;
          stall_ifof_c   = 1'b1;
          bubble_ofalu_c = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          stall_pc_c     = 1'b1;
          stall_ifof_c   = 1'b1;
          stall_ofalu_c  = 1'b1;
          bubble_aluma_c = 1'b1;
          cnt_d          = cnt_q - CNT_W'(1);
        end else begin
          state_d = RUN;
        end
      end
      HALT: begin
        stall_pc_c     = 1'b1;
        stall_ifof_c   = 1'b1;
        stall_ofalu_c  = 1'b1;
        bubble_aluma_c = 1'b1;
        halted_c       = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // Controls are forced low while reset is held, independent of inputs.
  assign stall_PC     = rst_n & stall_pc_c;
  assign stall_IFOF   = rst_n & stall_ifof_c;
  assign stall_OFALU  = rst_n & stall_ofalu_c;
  assign bubble_OFALU = rst_n & bubble_ofalu_c;
  assign flush_IFOF   = rst_n & flush_ifof_c;
  assign bubble_ALUMA = rst_n & bubble_aluma_c;
  assign halted       = rst_n & halted_c;
  assign state        = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall_PC && (stall_cycles_q != '1))
        stall_cycles_q <= stall_cycles_q + PERF_W'(1);
      if (flush_IFOF && (flush_count_q != '1))
        flush_count_q <= flush_count_q + PERF_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (MULDIV_CYCLES=4); counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        is_Ld_ALU, isWb_ALU, rp1_valid_OF, rp2_valid_OF;
  logic        branch_taken_ALU, is_MulDiv_ALU, is_Hlt_ALU;
  logic [4:0]  rd_ALU, RP1_OF, RP2_OF;
  logic        stall_PC, stall_IFOF, stall_OFALU, bubble_OFALU;
  logic        flush_IFOF, bubble_ALUMA, halted;
  logic [1:0]  state;
  logic [15:0] stall_cycles, flush_count;

  hazard_ctrl #(.MULDIV_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .is_Ld_ALU(is_Ld_ALU), .isWb_ALU(isWb_ALU), .rd_ALU(rd_ALU),
    .RP1_OF(RP1_OF), .rp1_valid_OF(rp1_valid_OF),
    .RP2_OF(RP2_OF), .rp2_valid_OF(rp2_valid_OF),
    .branch_taken_ALU(branch_taken_ALU), .is_MulDiv_ALU(is_MulDiv_ALU),
    .is_Hlt_ALU(is_Hlt_ALU),
    .stall_PC(stall_PC), .stall_IFOF(stall_IFOF), .stall_OFALU(stall_OFALU),
    .bubble_OFALU(bubble_OFALU), .flush_IFOF(flush_IFOF),
    .bubble_ALUMA(bubble_ALUMA), .halted(halted), .state(state),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // Control vector order: {stall_PC, stall_IFOF, stall_OFALU, bubble_OFALU, flush_IFOF, bubble_ALUMA, halted}
  localparam logic [6:0] C_NONE = 7'b000_0000;
  localparam logic [6:0] C_LU   = 7'b110_1000;
  localparam logic [6:0] C_BR   = 7'b000_1100;
  localparam logic [6:0] C_STL  = 7'b111_0010;
  localparam logic [6:0] C_HLT  = 7'b111_0011;

  // Input vector order: {ld, wb, rd, rp1, v1, rp2, v2, br, md, hlt}
  typedef struct packed {
    logic       ld;
    logic       wb;
    logic [4:0] rd;
    logic [4:0] rp1;
    logic       v1;
    logic [4:0] rp2;
    logic       v2;
    logic       br;
    logic       md;
    logic       hlt;
  } stim_t;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;

  logic [8:0] exp_q[$];
  string      tag_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input stim_t s);
    is_Ld_ALU        = s.ld;
    isWb_ALU         = s.wb;
    rd_ALU           = s.rd;
    RP1_OF           = s.rp1;
    rp1_valid_OF     = s.v1;
    RP2_OF           = s.rp2;
    rp2_valid_OF     = s.v2;
    branch_taken_ALU = s.br;
    is_MulDiv_ALU    = s.md;
    is_Hlt_ALU       = s.hlt;
  endtask

  function automatic logic [8:0] observed();
    return {stall_PC, stall_IFOF, stall_OFALU, bubble_OFALU, flush_IFOF,
            bubble_ALUMA, halted, state};
  endfunction

  // One cycle: drive, push expectation, compare at negedge, advance past posedge.
  task automatic step(input string tag, input stim_t s, input logic [6:0] ctl, input logic [1:0] st);
    logic [8:0] e;
    drive(s);
    exp_q.push_back({ctl, st});
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    check(tag_q.pop_front(), 32'(observed()), 32'(e));
    if (ctl[6]) exp_stall++;
    if (ctl[2]) exp_flush++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_perf(input string tag);
`ifdef HAZARD_PERF_CNT_EN
    check({tag, "_stall_cycles"}, 32'(stall_cycles), exp_stall);
    check({tag, "_flush_count"}, 32'(flush_count), exp_flush);
`else
    check({tag, "_stall_cycles"}, 32'(stall_cycles), 32'd0);
    check({tag, "_flush_count"}, 32'(flush_count), 32'd0);
`endif
  endtask

  stim_t s_none, s_lu, s_lu2, s_unused, s_nowb, s_md, s_br_lu, s_hlt, s_busy_noise;

  initial begin
    s_none       = '0;
    s_lu         = '{ld:1'b1, wb:1'b1, rd:5'd5, rp1:5'd5, v1:1'b1, rp2:5'd0, v2:1'b0, br:1'b0, md:1'b0, hlt:1'b0};
    s_lu2        = '{ld:1'b1, wb:1'b1, rd:5'd5, rp1:5'd6, v1:1'b1, rp2:5'd5, v2:1'b1, br:1'b0, md:1'b0, hlt:1'b0};
    s_unused     = '{ld:1'b1, wb:1'b1, rd:5'd5, rp1:5'd6, v1:1'b1, rp2:5'd5, v2:1'b0, br:1'b0, md:1'b0, hlt:1'b0};
    s_nowb       = '{ld:1'b1, wb:1'b0, rd:5'd5, rp1:5'd5, v1:1'b1, rp2:5'd0, v2:1'b0, br:1'b0, md:1'b0, hlt:1'b0};
    s_md         = '{ld:1'b0, wb:1'b0, rd:5'd0, rp1:5'd0, v1:1'b0, rp2:5'd0, v2:1'b0, br:1'b0, md:1'b1, hlt:1'b0};
    s_br_lu      = s_lu;
    s_br_lu.br   = 1'b1;
    s_hlt        = s_none;
    s_hlt.hlt    = 1'b1;
    s_busy_noise = s_lu;
    s_busy_noise.md = 1'b1;
    s_busy_noise.br = 1'b1;

    // Reset held with a live hazard and halt request on the inputs.
    rst_n = 1'b0;
    drive(s_hlt);
    is_Ld_ALU = 1'b1; isWb_ALU = 1'b1; rd_ALU = 5'd5; RP1_OF = 5'd5; rp1_valid_OF = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctl", 32'(observed()), 32'd0);
    check_perf("reset");
    drive(s_none);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    step("idle", s_none, C_NONE, 2'd0);
    step("lu_rp1", s_lu, C_LU, 2'd0);
    step("lu_clear", s_none, C_NONE, 2'd0);
    step("lu_rp2", s_lu2, C_LU, 2'd0);
    step("unused_rp2", s_unused, C_NONE, 2'd0);
    step("no_wb", s_nowb, C_NONE, 2'd0);

    step("md_start", s_md, C_STL, 2'd0);
    step("md_busy2", s_md, C_STL, 2'd1);
    step("md_busy1", s_busy_noise, C_STL, 2'd1);
    step("md_busy0", s_md, C_NONE, 2'd1);
    step("md_done", s_none, C_NONE, 2'd0);
    check_perf("after_md");

    step("br_lu", s_br_lu, C_BR, 2'd0);
    step("br_after", s_none, C_NONE, 2'd0);
    check_perf("after_br");

    step("hlt_enter", s_hlt, C_STL, 2'd0);
    for (int i = 0; i < 22; i++)
      step($sformatf("halt_%0d", i), (i % 3 == 0) ? s_busy_noise : s_none, C_HLT, 2'd2);
    check_perf("in_halt");

    // Reset mid-halt must clear outputs before the next edge.
    rst_n = 1'b0;
    #1;
    check("halt_reset_ctl", 32'(observed()), 32'd0);
    exp_stall = 0;
    exp_flush = 0;
    check_perf("halt_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("post_reset", s_none, C_NONE, 2'd0);

    // One mul/div then one load-use: four stall cycles.
    step("perf_md0", s_md, C_STL, 2'd0);
    step("perf_md1", s_none, C_STL, 2'd1);
    step("perf_md2", s_none, C_STL, 2'd1);
    step("perf_md3", s_none, C_NONE, 2'd1);
    step("perf_lu", s_lu, C_LU, 2'd0);
    step("perf_idle", s_none, C_NONE, 2'd0);
`ifdef HAZARD_PERF_CNT_EN
    check("perf_total", 32'(stall_cycles), 32'd4);
`else
    check("perf_total", 32'(stall_cycles), 32'd0);
`endif
    check_perf("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
